chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//   Parametrised multi-cycle add/subtract unit. It is the successor to the fixed 4-bit combinational adders.
//   It adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks.
//   Trades latency for area in the datapath; a start/done handshake toward the controlling FSM.
//   Adds subtract mode and signed overflow detection.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK   4  bits processed per clock; 1 <= CHUNK <= WIDTH
//   (derived) NCHUNK = WIDTH/CHUNK, chunk counter width = clog2(NCHUNK), min 1
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; accepted only when ready=1
//   a      in   WIDTH  operand A, sampled on accepted start
//   b      in   WIDTH  operand B, sampled on accepted start
//   cin    in   1      carry-in, sampled on accepted start
//   sub    in   1      0 = add, 1 = subtract; sampled on accepted start
//   ready  out  1      1 in IDLE only
//   busy   out  1      1 in RUN only
//   done   out  1      one-cycle pulse in DONE
//   s      out  WIDTH  result
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE.
//     - s=0, cout=0, ovf=0, done=0, busy=0, ready=1 after the edge.
//     - Reset overrides start in the same cycle.
//     - Reset mid-RUN aborts the operation: no done pulse, results zeroed.
//   FSM states:
//     - IDLE: on start=1, latch a, beff = sub ? ~b : b, carry = cin ^ sub; clear s; idx=0. Next state RUN.
//     - RUN: compute {c,sum} = a[idx*CHUNK+:CHUNK] + beff[idx*CHUNK+:CHUNK] + carry.
//       Write s[idx*CHUNK+:CHUNK] = sum and carry = c; idx++.
//       After the chunk with idx=NCHUNK-1, next state DONE.
//     - DONE: done=1 for exactly one cycle; cout=carry.
//       ovf = (a[W-1]==beff[W-1]) && (s[W-1]!=a[W-1]). Next state IDLE.
//   Timing:
//     - Latency: start accepted at edge t; done=1 during cycle t+NCHUNK+1. With 16/4 that is 5 cycles.
//     - Throughput: one op per NCHUNK+2 cycles.
//   Handshake and output stability:
//     - start is ignored while not IDLE, including during DONE; operand changes during RUN have no effect.
//     - s may show partial chunks during RUN.
//     - s, cout and ovf are valid from DONE and hold until the next accepted start or reset.
//     - cout and ovf are held (not updated) during RUN.
//   Arithmetic:
//     - Result is modulo 2^WIDTH.
//     - sub=1,cin=0 gives a-b; sub=1,cin=1 gives a-b-1.
//     - In subtract mode, cout=1 means no borrow.
//   CHUNK=WIDTH is legal: single RUN cycle, latency 2.
// TESTING (WIDTH=16, CHUNK=4 unless noted)
//   1. Hold rst 2 cycles, start=1 -> s=0, cout=0, ovf=0, done=0, ready=1, busy=0.
//   2. a=00FF, b=0001, cin=0, sub=0 -> done exactly 5 cycles after start; s=0100, cout=0, ovf=0.
//   3. a=FFFF, b=0001 -> s=0000, cout=1, ovf=0.
//      a=7FFF, b=0001 -> s=8000, cout=0, ovf=1.
//   4. sub=1: a=0005, b=0007, cin=0 -> s=FFFE, cout=0, ovf=0.
//      a=8000, b=0001, sub=1 -> s=7FFF, cout=1, ovf=1.
//   5. Pulse start again during RUN and in DONE; change a/b mid-RUN.
//      Required: exactly one done pulse, unchanged result.
//      Then assert rst during RUN cycle 2 -> no done pulse, IDLE, s=0.
//   6. Sweep WIDTH=4 with CHUNK=1, 2 and 4: all 512 {a,b,cin} combinations, sub=0 and sub=1.
//      Compare against a+beff+(cin^sub) for s/cout/ovf; check latency NCHUNK+1 every time.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder_if
// Description : start/done handshake and operand/result bundle for the
//               chunked serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  ready, busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, busy, done, s, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : multi-cycle add/subtract, CHUNK bits per clock with a
//               registered ripple carry and signed overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  chunked_serial_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   chunk_sum;

  // Operands shift right each RUN cycle so the active chunk is always at
  // bit 0; on the last chunk that slice holds the original sign bits.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, beff_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          beff_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          s_d     = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        beff_d  = beff_q >> CHUNK;
        s_d     = (s_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_q[CHUNK-1] == beff_q[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = (state_q == S_DONE);
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_serial_adder
// Description : self-checking bench: vector table, handshake/reset corners,
//               random 16-bit ops and an exhaustive 4-bit sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(16)) m_if ();
  chunked_serial_adder_if #(.WIDTH(4))  c1_if ();
  chunked_serial_adder_if #(.WIDTH(4))  c2_if ();
  chunked_serial_adder_if #(.WIDTH(4))  c4_if ();

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(m_if));
  chunked_serial_adder #(.WIDTH(4),  .CHUNK(1)) u_c1  (.clk(clk), .rst(rst), .bus(c1_if));
  chunked_serial_adder #(.WIDTH(4),  .CHUNK(2)) u_c2  (.clk(clk), .rst(rst), .bus(c2_if));
  chunked_serial_adder #(.WIDTH(4),  .CHUNK(4)) u_c4  (.clk(clk), .rst(rst), .bus(c4_if));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: true integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint m    = longint'(1) << w;
    longint half = m >> 1;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint ci   = longint'(cin);
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sb   = (ub >= half) ? ub - m : ub;
    longint ur;
    longint sr;
    if (!sub) begin
      ur     = ua + ub + ci;
      sr     = sa + sb + ci;
      r.cout = (ur >= m);
    end else begin
      ur     = ua - ub - ci;
      sr     = sa - sb - ci;
      r.cout = (ur >= 0);
    end
    r.ovf = (sr >= half) || (sr < -half);
    r.s   = 16'(ur & (m - 1));
    return r;
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, output int lat, output res_t r);
    int guard = 0;
    while (!m_if.ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    m_if.a = a; m_if.b = b; m_if.cin = cin; m_if.sub = sub; m_if.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      m_if.start = 1'b0;
      lat++;
    end while (!m_if.done && lat < 40);
    r.s = m_if.s; r.cout = m_if.cout; r.ovf = m_if.ovf;
  endtask

  task automatic drive_small(input logic [3:0] a, input logic [3:0] b,
                             input logic cin, input logic sub, input logic start);
    c1_if.a = a; c1_if.b = b; c1_if.cin = cin; c1_if.sub = sub; c1_if.start = start;
    c2_if.a = a; c2_if.b = b; c2_if.cin = cin; c2_if.sub = sub; c2_if.start = start;
    c4_if.a = a; c4_if.b = b; c4_if.cin = cin; c4_if.sub = sub; c4_if.start = start;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    res_t r, e;
    res_t got [3];
    int   lat;
    int   lats [3];
    int   pulses;
    logic [15:0] held_s;

    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[6] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    m_if.start = 1'b1; m_if.a = 16'hAAAA; m_if.b = 16'h5555; m_if.cin = 1'b1; m_if.sub = 1'b0;
    drive_small(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with start asserted.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", 32'(m_if.s), 32'h0);
    chk("rst_cout", 32'(m_if.cout), 32'h0);
    chk("rst_ovf", 32'(m_if.ovf), 32'h0);
    chk("rst_done", 32'(m_if.done), 32'h0);
    chk("rst_ready", 32'(m_if.ready), 32'h1);
    chk("rst_busy", 32'(m_if.busy), 32'h0);
    m_if.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      op16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, r);
      chk("tbl_lat", 32'(lat), 32'd5);
      chk("tbl_s", 32'(r.s), 32'(tbl[i].s));
      chk("tbl_cout", 32'(r.cout), 32'(tbl[i].cout));
      chk("tbl_ovf", 32'(r.ovf), 32'(tbl[i].ovf));
      @(posedge clk); #1;
      chk("tbl_hold_s", 32'(m_if.s), 32'(tbl[i].s));
    end

    // Start pulses during RUN and DONE, operands scrambled mid-run.
    m_if.a = 16'h1111; m_if.b = 16'h2222; m_if.cin = 1'b0; m_if.sub = 1'b0; m_if.start = 1'b1;
    pulses = 0;
    held_s = 16'h0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (m_if.done) begin
        pulses++;
        held_s = m_if.s;
      end
      if (m_if.busy) begin
        m_if.a = 16'($urandom); m_if.b = 16'($urandom); m_if.cin = 1'b1; m_if.sub = 1'b1;
      end
      if (m_if.ready) m_if.start = 1'b0;
    end
    chk("hs_pulses", 32'(pulses), 32'd1);
    chk("hs_done_s", 32'(held_s), 32'h3333);
    chk("hs_hold_s", 32'(m_if.s), 32'h3333);
    chk("hs_ready", 32'(m_if.ready), 32'h1);

    // Reset during RUN cycle 2 aborts and zeroes results.
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, r);
    chk("pre_abort_cout", 32'(r.cout), 32'h1);
    @(posedge clk); #1;
    m_if.a = 16'h7654; m_if.b = 16'h1111; m_if.cin = 1'b0; m_if.sub = 1'b0; m_if.start = 1'b1;
    @(posedge clk); #1;
    m_if.start = 1'b0;
    chk("abort_busy1", 32'(m_if.busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(m_if.ready), 32'h1);
    chk("abort_busy", 32'(m_if.busy), 32'h0);
    chk("abort_s", 32'(m_if.s), 32'h0);
    chk("abort_cout", 32'(m_if.cout), 32'h0);
    chk("abort_ovf", 32'(m_if.ovf), 32'h0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m_if.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // Random 16-bit operations.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000 | ra;
      op16(ra, rb, rc, rs, lat, r);
      e = model(16, ra, rb, rc, rs);
      chk("rnd_lat", 32'(lat), 32'd5);
      chk("rnd_s", 32'(r.s), 32'(e.s));
      chk("rnd_cout", 32'(r.cout), 32'(e.cout));
      chk("rnd_ovf", 32'(r.ovf), 32'(e.ovf));
    end

    // Exhaustive 4-bit sweep for CHUNK = 1, 2, 4.
    for (int sb = 0; sb < 2; sb++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          for (int ic = 0; ic < 2; ic++) begin
            logic [2:0] seen;
            int         cyc;
            drive_small(4'(ia), 4'(ib), 1'(ic), 1'(sb), 1'b1);
            seen = 3'b000;
            cyc  = 0;
            for (int k = 0; k < 3; k++) lats[k] = 0;
            while (seen != 3'b111 && cyc < 20) begin
              @(posedge clk); #1;
              cyc++;
              c1_if.start = 1'b0; c2_if.start = 1'b0; c4_if.start = 1'b0;
              if (!seen[0] && c1_if.done) begin
                seen[0] = 1'b1; lats[0] = cyc; got[0] = '{{12'h0, c1_if.s}, c1_if.cout, c1_if.ovf};
              end
              if (!seen[1] && c2_if.done) begin
                seen[1] = 1'b1; lats[1] = cyc; got[1] = '{{12'h0, c2_if.s}, c2_if.cout, c2_if.ovf};
              end
              if (!seen[2] && c4_if.done) begin
                seen[2] = 1'b1; lats[2] = cyc; got[2] = '{{12'h0, c4_if.s}, c4_if.cout, c4_if.ovf};
              end
            end
            @(posedge clk); #1;
            e = model(4, 16'(ia), 16'(ib), 1'(ic), 1'(sb));
            chk("sw_c1_lat", 32'(lats[0]), 32'd5);
            chk("sw_c2_lat", 32'(lats[1]), 32'd3);
            chk("sw_c4_lat", 32'(lats[2]), 32'd2);
            for (int k = 0; k < 3; k++) begin
              chk("sw_s", 32'(got[k].s), 32'(e.s));
              chk("sw_cout", 32'(got[k].cout), 32'(e.cout));
              chk("sw_ovf", 32'(got[k].ovf), 32'(e.ovf));
            end
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
